hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Downstream/control stage wrapped around the sequential shift-add multiplier in the MIPS datapath.
- Accepts MULT(U)/MTHI/MTLO/MFHI/MFLO requests from the execute stage.
- Launches the multiplier, counts its fixed latency and captures the 2*WIDTH product into HI/LO.
- Stalls the pipeline whenever HI/LO is read or rewritten while a multiply is in flight.

Parameters:
- WIDTH, 16, operand width; HI and LO are WIDTH bits each; product is 2*WIDTH bits.
- MUL_CYCLES, 2*WIDTH, cycles from the multiplier start edge until the product is valid.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- A  in  WIDTH  rs operand; multiplicand for MULT, data for MTHI/MTLO.
- B  in  WIDTH  rt operand; multiplier for MULT.
- Op_mult  in  1  start a multiply with A*B.
- Op_mthi  in  1  HI <= A.
- Op_mtlo  in  1  LO <= A.
- Rd_hi  in  1  MFHI request.
- Rd_lo  in  1  MFLO request.
- Mul_product  in  2*WIDTH  product bus from the multiplier.
- Mul_start  out  1  start strobe to the multiplier (its Sy input).
- Mul_a  out  WIDTH  multiplicand; combinational in the start cycle.
- Mul_a_reg  out  WIDTH  registered multiplicand; stable for the whole operation.
- Mul_b  out  WIDTH  multiplier operand.
- Hilo_out  out  WIDTH  MFHI/MFLO read data.
- Busy  out  1  multiply in flight.
- Stall  out  1  hold the upstream pipeline.

Behaviour:
- Reset values: HI=0, LO=0, state IDLE, count=0, Mul_a_reg=0, Mul_start=0, Busy=0, Stall=0. Hilo_out is then 0.
- State IDLE:
  - Op_mult=1: Mul_start=1 combinationally for this single cycle. Mul_a=A, Mul_b=B this cycle.
  - At the edge: Mul_a_reg<=A, count<=0, state->RUN.
- State RUN:
  - Mul_start=0, Busy=1. Mul_a and Mul_b are driven from registered copies, held constant.
  - count increments each edge.
  - At the edge where count==MUL_CYCLES-1: {HI,LO}<=Mul_product, state->IDLE.
  - Latency: product lands in HI/LO exactly MUL_CYCLES edges after the start edge.
- Stall = Busy & (Op_mult | Op_mthi | Op_mtlo | Rd_hi | Rd_lo). This includes the final RUN cycle.
  - A stalled request has no effect and must be held by upstream until Stall drops.
- Reads are combinational from HI/LO: Hilo_out = Rd_hi ? HI : (Rd_lo ? LO : 0). Rd_hi wins if both are asserted.
- Writes (IDLE only): Op_mthi and Op_mtlo together write both registers with A.
- Op_mult has priority over MTHI/MTLO in the same cycle; the moves are dropped, and this is a flagged usage error.
- Reset mid-operation: immediate return to reset values. The multiplier is reset by the same Reset, so no partial product is ever captured.
- Unsigned arithmetic by default; the product is taken verbatim.

Optional Feature:
- Macro: HILO_SIGNED_MULT_EN
- With the macro: adds input Op_signed (1 bit), qualifying Op_mult.
  - When set: operands are converted to magnitude (two's-complement negate if MSB=1) before driving Mul_a/Mul_a_reg/Mul_b.
  - The result sign (A[MSB]^B[MSB]) is registered at start; the product is negated on capture if that sign is set.
  - The most-negative operand magnitude fits in WIDTH unsigned bits, so no overflow.
- Without the macro: the port is absent and only MULTU semantics exist.

Decomposition:
- Package hilo_pkg: state enum {IDLE, RUN}; localparam CNT_W = $clog2(MUL_CYCLES).
- One natural sub-module: hilo_regs, holding the HI/LO storage plus write-priority and read-mux logic.
- The FSM/counter stays in hilo_unit.

Test Plan:
- Unsigned multiply (WIDTH=16, MUL_CYCLES=32): Op_mult with A=3, B=5.
  - Busy=1 for 32 cycles, Mul_start high for exactly 1 cycle.
  - Then MFLO returns 15 and MFHI returns 0.
- Full-scale multiply: A=16'hFFFF, B=16'hFFFF.
  - HI=16'hFFFE, LO=16'h0001 after 32 cycles.
- Reads during a multiply: Rd_lo asserted on cycle 5 of RUN.
  - Stall=1 until the capture edge; the first unstalled read returns the new LO.
- Moves: MTHI A=16'h1234 then MTLO A=16'hABCD in IDLE.
  - MFHI returns 16'h1234, MFLO returns 16'hABCD.
  - MTHI issued during RUN stalls and leaves HI unchanged.
- Reset at RUN cycle 10 of a 7*9 multiply: HI=LO=0, Busy=0 immediately.
  - A subsequent 2*2 multiply yields LO=4.
- HILO_SIGNED_MULT_EN: signed multiply A=-3 (16'hFFFD), B=5.
  - HI=16'hFFFF, LO=16'hFFF1.
  - A=16'h8000, B=16'h8000 gives HI=16'h4000, LO=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Purpose: shared types and helpers for the HI/LO multiply control slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hilo_pkg;

    // Control FSM: IDLE accepts requests, RUN waits out the multiplier latency.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 16;

    // Latency counter width; never below one bit, so a 1-cycle multiplier still works.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// Purpose: HI/LO storage with product-capture priority over moves, plus MFHI/MFLO read mux.
// Latency: writes land on the next Clk edge; reads are combinational.
// Backpressure: none; the caller decides when wr_hi/wr_lo/cap may fire.
//
// Ports: clk/rst (async active-high), a = move data, wr_hi/wr_lo = MTHI/MTLO strobes,
//        cap/cap_dat = product capture into {HI,LO}, rd_hi/rd_lo/rd_dat = read port.
module hilo_regs #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic               wr_hi,
    input  logic               wr_lo,
    input  logic               cap,
    input  logic [2*WIDTH-1:0] cap_dat,
    input  logic               rd_hi,
    input  logic               rd_lo,
    output logic [WIDTH-1:0]   rd_dat
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (cap) begin
            {hi, lo} <= cap_dat;
        end else begin
            // MTHI and MTLO together write A into both halves.
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
        end
    end

    // HI wins when both reads are requested.
    always_comb begin
        rd_dat = '0;
        if (rd_hi)      rd_dat = hi;
        else if (rd_lo) rd_dat = lo;
    end

endmodule

// File: rtl/hilo_unit.sv
// Purpose: MIPS HI/LO control stage; launches the shift-add multiplier and captures its product.
// Latency: product lands in HI/LO exactly MUL_CYCLES edges after the start edge; moves take 1 edge.
// Backpressure: Stall holds upstream whenever any HI/LO request arrives while a multiply is in flight.
//
// Ports: Clk, Reset (async active-high); A/B operands; Op_mult/Op_mthi/Op_mtlo/Rd_hi/Rd_lo requests;
//        Mul_product from the multiplier; Mul_start/Mul_a/Mul_a_reg/Mul_b to it; Hilo_out read data;
//        Busy (multiply in flight); Stall. Optional macro HILO_SIGNED_MULT_EN adds Op_signed.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int MUL_CYCLES = 2 * WIDTH
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               Op_mult,
`ifdef HILO_SIGNED_MULT_EN
    input  logic               Op_signed,
`endif
    input  logic               Op_mthi,
    input  logic               Op_mtlo,
    input  logic               Rd_hi,
    input  logic               Rd_lo,
    input  logic [2*WIDTH-1:0] Mul_product,
    output logic               Mul_start,
    output logic [WIDTH-1:0]   Mul_a,
    output logic [WIDTH-1:0]   Mul_a_reg,
    output logic [WIDTH-1:0]   Mul_b,
    output logic [WIDTH-1:0]   Hilo_out,
    output logic               Busy,
    output logic               Stall
);

    localparam int              CNT_W    = cnt_width(MUL_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MUL_CYCLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] cap_dat;
    logic               run;
    logic               cap;
    logic               any_req;

`ifdef HILO_SIGNED_MULT_EN
    // The multiplier is unsigned: feed it magnitudes and fix the sign on capture.
    logic neg_q;
    assign mag_a   = (Op_signed && A[WIDTH-1]) ? -A : A;
    assign mag_b   = (Op_signed && B[WIDTH-1]) ? -B : B;
    assign cap_dat = neg_q ? -Mul_product : Mul_product;
`else
    assign mag_a   = A;
    assign mag_b   = B;
    assign cap_dat = Mul_product;
`endif

    assign run     = (state == RUN);
    assign cap     = run && (count == LAST_CNT);
    assign any_req = Op_mult | Op_mthi | Op_mtlo | Rd_hi | Rd_lo;

    assign Busy      = run;
    assign Stall     = run & any_req;
    assign Mul_start = ~run & Op_mult;
    // Operands pass straight through in the start cycle, then come from the held copies.
    assign Mul_a     = run ? a_reg : mag_a;
    assign Mul_b     = run ? b_reg : mag_b;
    assign Mul_a_reg = a_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            count <= '0;
            a_reg <= '0;
            b_reg <= '0;
`ifdef HILO_SIGNED_MULT_EN
            neg_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Op_mult) begin
                        a_reg <= mag_a;
                        b_reg <= mag_b;
                        count <= '0;
                        state <= RUN;
`ifdef HILO_SIGNED_MULT_EN
                        neg_q <= Op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
`endif
                    end
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    if (count == LAST_CNT) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moves only take effect in IDLE; a same-cycle Op_mult drops them.
    hilo_regs #(.WIDTH(WIDTH)) u_regs (
        .clk     (Clk),
        .rst     (Reset),
        .a       (A),
        .wr_hi   (~run & ~Op_mult & Op_mthi),
        .wr_lo   (~run & ~Op_mult & Op_mtlo),
        .cap     (cap),
        .cap_dat (cap_dat),
        .rd_hi   (Rd_hi),
        .rd_lo   (Rd_lo),
        .rd_dat  (Hilo_out)
    );

endmodule

// File: tb/tb_hilo_unit.sv
// Purpose: self-checking bench for hilo_unit with a behavioural HI/LO model and a latency-exact multiplier model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hilo_unit;

    localparam int W  = 16;
    localparam int MC = 32;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [W-1:0]  A = '0;
    logic [W-1:0]  B = '0;
    logic          Op_mult = 1'b0;
    logic          op_sgn = 1'b0;
    logic          Op_mthi = 1'b0;
    logic          Op_mtlo = 1'b0;
    logic          Rd_hi = 1'b0;
    logic          Rd_lo = 1'b0;
    logic [2*W-1:0] Mul_product;
    logic          Mul_start;
    logic [W-1:0]  Mul_a;
    logic [W-1:0]  Mul_a_reg;
    logic [W-1:0]  Mul_b;
    logic [W-1:0]  Hilo_out;
    logic          Busy;
    logic          Stall;

    hilo_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .A           (A),
        .B           (B),
        .Op_mult     (Op_mult),
`ifdef HILO_SIGNED_MULT_EN
        .Op_signed   (op_sgn),
`endif
        .Op_mthi     (Op_mthi),
        .Op_mtlo     (Op_mtlo),
        .Rd_hi       (Rd_hi),
        .Rd_lo       (Rd_lo),
        .Mul_product (Mul_product),
        .Mul_start   (Mul_start),
        .Mul_a       (Mul_a),
        .Mul_a_reg   (Mul_a_reg),
        .Mul_b       (Mul_b),
        .Hilo_out    (Hilo_out),
        .Busy        (Busy),
        .Stall       (Stall)
    );

    initial forever #5 Clk = ~Clk;

    int n_vec = 0;
    int n_cmp = 0;
    int miscompares = 0;
    int cnt_busy = 0;
    int cnt_start = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] mag(input logic [W-1:0] v, input bit s);
        return (s && v[W-1]) ? W'(-v) : v;
    endfunction

    function automatic logic [2*W-1:0] full_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        int sa;
        int sb;
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 32'(sa * sb);
        end
        return 32'(a) * 32'(b);
    endfunction

    logic [W-1:0]   m_hi = '0, m_lo = '0, m_areg = '0, m_breg = '0;
    logic [2*W-1:0] m_res = '0;
    int             m_left = 0;   // cycles of RUN still to go

    initial forever begin
        @(posedge Clk or posedge Reset);
        if (Reset) begin
            m_hi = '0; m_lo = '0; m_areg = '0; m_breg = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) {m_hi, m_lo} = m_res;
        end else if (Op_mult) begin
            m_left = MC;
            m_areg = mag(A, op_sgn);
            m_breg = mag(B, op_sgn);
            m_res  = full_prod(A, B, op_sgn);
        end else begin
            if (Op_mthi) m_hi = A;
            if (Op_mtlo) m_lo = A;
        end
    end

    // Multiplier model: random garbage except in the single cycle before the product is due.
    logic [W-1:0] mp_a = '0, mp_b = '0;
    int           mp_left = 0;
    initial begin
        Mul_product = '0;
        forever begin
            @(negedge Clk);
            Mul_product = $urandom;
            if (Reset) begin
                mp_left = 0;
            end else begin
                if (mp_left > 0) begin
                    mp_left--;
                    if (mp_left == 0) Mul_product = 32'(mp_a) * 32'(mp_b);
                end
                if (Mul_start) begin
                    mp_left = MC;
                    mp_a = Mul_a;
                    mp_b = Mul_b;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        bit busy;
        bit anyop;
        bit st;
        logic [W-1:0] eh;
        @(negedge Clk);
        n_vec++;
        busy  = (m_left > 0);
        anyop = Op_mult | Op_mthi | Op_mtlo | Rd_hi | Rd_lo;
        st    = !busy && Op_mult && !Reset;
        eh    = Rd_hi ? m_hi : (Rd_lo ? m_lo : '0);
        if (Busy) cnt_busy++;
        if (Mul_start) cnt_start++;
        chk("busy", 32'(Busy), 32'(busy));
        chk("stall", 32'(Stall), 32'(busy && anyop));
        chk("mul_start", 32'(Mul_start), 32'(st));
        chk("hilo_out", 32'(Hilo_out), 32'(eh));
        chk("mul_a_reg", 32'(Mul_a_reg), 32'(m_areg));
        if (busy) begin
            chk("mul_a_run", 32'(Mul_a), 32'(m_areg));
            chk("mul_b_run", 32'(Mul_b), 32'(m_breg));
        end else if (st) begin
            chk("mul_a_start", 32'(Mul_a), 32'(mag(A, op_sgn)));
            chk("mul_b_start", 32'(Mul_b), 32'(mag(B, op_sgn)));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit s);
        A = a; B = b; op_sgn = s; Op_mult = 1'b1;
        cyc();
        Op_mult = 1'b0;
        op_sgn = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge Clk);
            done = !Busy;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL wait_idle: Busy still 1 after 200 cycles, required 0");
        end
        cyc();
    endtask

    task automatic rd(input bit hi, input logic [W-1:0] exp, input string nm);
        Rd_hi = hi; Rd_lo = !hi;
        @(negedge Clk);
        chk(nm, 32'(Hilo_out), 32'(exp));
        cyc();
        Rd_hi = 1'b0; Rd_lo = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_n;
        bit done;
        // Reset state
        Rd_hi = 1'b1;
        cyc(); cyc();
        @(negedge Clk);
        chk("reset_busy", 32'(Busy), 0);
        chk("reset_stall", 32'(Stall), 0);
        chk("reset_hilo", 32'(Hilo_out), 0);
        chk("reset_areg", 32'(Mul_a_reg), 0);
        chk("reset_start", 32'(Mul_start), 0);
        cyc();
        Rd_hi = 1'b0;
        Reset = 1'b0;
        cyc();

        // 3*5: 32 busy cycles, one start pulse
        cnt_busy = 0; cnt_start = 0;
        start_mult(16'd3, 16'd5, 1'b0);
        wait_idle();
        chk("busy_cycles", 32'(cnt_busy), 32'(MC));
        chk("start_pulses", 32'(cnt_start), 1);
        chk("areg_3", 32'(Mul_a_reg), 3);
        rd(1'b0, 16'd15, "mflo_3x5");
        rd(1'b1, 16'd0,  "mfhi_3x5");

        // Full scale
        start_mult(16'hFFFF, 16'hFFFF, 1'b0);
        wait_idle();
        rd(1'b1, 16'hFFFE, "mfhi_ffff");
        rd(1'b0, 16'h0001, "mflo_ffff");

        // Read stalled from RUN cycle 5 until capture
        start_mult(16'd100, 16'd7, 1'b0);
        for (int i = 0; i < 5; i++) cyc();
        Rd_lo = 1'b1;
        stall_n = 0;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge Clk);
            if (Stall) begin
                stall_n++;
                cyc();
            end else begin
                done = 1;
            end
        end
        chk("stall_cycles", 32'(stall_n), 32'(MC - 5));
        chk("first_unstalled_lo", 32'(Hilo_out), 32'd700);
        cyc();
        Rd_lo = 1'b0;

        // Moves in IDLE
        A = 16'h1234; Op_mthi = 1'b1; cyc(); Op_mthi = 1'b0;
        A = 16'hABCD; Op_mtlo = 1'b1; cyc(); Op_mtlo = 1'b0;
        rd(1'b1, 16'h1234, "mfhi_move");
        rd(1'b0, 16'hABCD, "mflo_move");

        // MTHI during RUN is stalled and ignored
        start_mult(16'd2, 16'd3, 1'b0);
        A = 16'h5555; Op_mthi = 1'b1; Rd_hi = 1'b1;
        cyc(); cyc(); cyc();
        @(negedge Clk);
        chk("mthi_run_stall", 32'(Stall), 1);
        chk("mthi_run_hi_kept", 32'(Hilo_out), 32'h1234);
        cyc();
        Op_mthi = 1'b0; Rd_hi = 1'b0;
        wait_idle();
        rd(1'b1, 16'd0, "mfhi_2x3");
        rd(1'b0, 16'd6, "mflo_2x3");

        // Mult beats a same-cycle move
        A = 16'd4; B = 16'd4; Op_mult = 1'b1; Op_mtlo = 1'b1;
        cyc();
        Op_mult = 1'b0; Op_mtlo = 1'b0;
        wait_idle();
        rd(1'b0, 16'd16, "mflo_mult_priority");

        // Reset at RUN cycle 10
        start_mult(16'd7, 16'd9, 1'b0);
        for (int i = 0; i < 10; i++) cyc();
        Reset = 1'b1;
        #1;
        chk("midreset_busy", 32'(Busy), 0);
        cyc();
        Reset = 1'b0;
        rd(1'b1, 16'd0, "mfhi_after_reset");
        rd(1'b0, 16'd0, "mflo_after_reset");
        start_mult(16'd2, 16'd2, 1'b0);
        wait_idle();
        rd(1'b0, 16'd4, "mflo_2x2");

`ifdef HILO_SIGNED_MULT_EN
        start_mult(16'hFFFD, 16'd5, 1'b1);
        chk("areg_signed", 32'(Mul_a_reg), 3);
        wait_idle();
        rd(1'b1, 16'hFFFF, "mfhi_m3x5");
        rd(1'b0, 16'hFFF1, "mflo_m3x5");
        start_mult(16'h8000, 16'h8000, 1'b1);
        wait_idle();
        rd(1'b1, 16'h4000, "mfhi_8000sq");
        rd(1'b0, 16'h0000, "mflo_8000sq");
`endif

        // Randomized traffic, every cycle checked against the model
        for (int i = 0; i < 900; i++) begin
            A       = 16'($urandom);
            B       = 16'($urandom);
            Op_mult = ($urandom_range(0, 19) == 0);
`ifdef HILO_SIGNED_MULT_EN
            op_sgn  = 1'($urandom);
`endif
            Op_mthi = ($urandom_range(0, 9) == 0);
            Op_mtlo = ($urandom_range(0, 9) == 0);
            Rd_hi   = ($urandom_range(0, 3) == 0);
            Rd_lo   = ($urandom_range(0, 3) == 0);
            cyc();
        end
        Op_mult = 1'b0; op_sgn = 1'b0; Op_mthi = 1'b0; Op_mtlo = 1'b0;
        Rd_hi = 1'b0; Rd_lo = 1'b0;
        wait_idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
